// File: rtl/wdt_pkg.sv
// Shared types and helpers for the watchdog reset-pulse generator.
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNT     = 2'd1,
    ST_INTR_WAIT = 2'd2,
    ST_RST_PULSE = 2'd3
  } wdt_state_e;

  localparam int RPL_W = 3;
  localparam int PLS_W = 9;

  // Pulse length in cycles for a given code: 2^(code+1), 2..256.
  function automatic logic [PLS_W-1:0] rpl_len(input logic [RPL_W-1:0] code);
    logic [PLS_W-1:0] one;
    one = PLS_W'(1);
    return one << (int'(code) + 1);
  endfunction

endpackage

// File: rtl/wdt_rst_pulse.sv
// Reset pulse shaper: on start, drives wdt_rst high for rpl_len(code) cycles.
module wdt_rst_pulse
  import wdt_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             start,
  input  logic [RPL_W-1:0] code,
  output logic             wdt_rst,
  output logic             done
);

  logic [PLS_W-1:0] pcnt_q, pcnt_d;
  logic             wdt_rst_q, wdt_rst_d;

  // The code only matters at start; loading N-1 here is what freezes it.
  always_comb begin
    pcnt_d    = pcnt_q;
    wdt_rst_d = wdt_rst_q;
    if (start) begin
      wdt_rst_d = 1'b1;
      pcnt_d    = rpl_len(code) - PLS_W'(1);
    end else if (wdt_rst_q) begin
      if (pcnt_q == '0) wdt_rst_d = 1'b0;
      else              pcnt_d    = pcnt_q - PLS_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pcnt_q    <= '0;
      wdt_rst_q <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      wdt_rst_q <= wdt_rst_d;
    end
  end

  assign wdt_rst = wdt_rst_q;
  assign done    = wdt_rst_q && (pcnt_q == '0);

endmodule

// File: rtl/wdt_rst_pulse_gen.sv
// Watchdog core: timeout down-counter, optional interrupt stage, reset pulse.
// state        | meaning
// ST_IDLE      | disabled, counter held at 0
// ST_COUNT     | counting down toward first timeout
// ST_INTR_WAIT | interrupt raised, counting toward second timeout
// ST_RST_PULSE | reset pulse in progress, all kicks ignored
module wdt_rst_pulse_gen
  import wdt_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int HC_RPL   = 0,
  parameter int DFLT_RPL = 0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             wdt_en,
  input  logic             rmod,
  input  logic             restart,
  input  logic             intr_clr,
  input  logic [CNT_W-1:0] top,
  input  logic [RPL_W-1:0] rpl,
  output logic             wdt_rst,
  output logic             wdt_intr,
  output logic [CNT_W-1:0] cnt_val
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             intr_q, intr_d;
  logic             pulse_start, pulse_done;
  logic             kick, tc;
  logic [RPL_W-1:0] rpl_eff;

  assign kick    = restart | intr_clr;
  assign tc      = (cnt_q == '0);
  assign rpl_eff = (HC_RPL != 0) ? RPL_W'(DFLT_RPL) : rpl;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intr_q  <= intr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (wdt_en) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!wdt_en)   state_d = ST_IDLE;
        else if (kick) state_d = ST_COUNT;
        else if (tc)   state_d = rmod ? ST_INTR_WAIT : ST_RST_PULSE;
      end
      ST_INTR_WAIT: begin
        if (!wdt_en)   state_d = ST_IDLE;
        else if (kick) state_d = ST_COUNT;
        else if (tc)   state_d = ST_RST_PULSE;
      end
      ST_RST_PULSE: if (pulse_done) state_d = wdt_en ? ST_COUNT : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    intr_d      = intr_q;
    pulse_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = wdt_en ? top : '0;
        intr_d = 1'b0;
      end
      ST_COUNT, ST_INTR_WAIT: begin
        if (!wdt_en) begin
          cnt_d  = '0;
          intr_d = 1'b0;
        end else if (kick) begin
          cnt_d  = top;
          intr_d = 1'b0;
        end else if (tc) begin
          // First timeout in interrupt mode arms the second stage instead of firing.
          if (state_q == ST_COUNT && rmod) begin
            intr_d = 1'b1;
            cnt_d  = top;
          end else begin
            pulse_start = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RST_PULSE: begin
        if (pulse_done) begin
          intr_d = 1'b0;
          cnt_d  = wdt_en ? top : '0;
        end
      end
      default: begin
        cnt_d  = '0;
        intr_d = 1'b0;
      end
    endcase
  end

  wdt_rst_pulse u_pulse (
    .pclk    (pclk),
    .rst     (rst),
    .start   (pulse_start),
    .code    (rpl_eff),
    .wdt_rst (wdt_rst),
    .done    (pulse_done)
  );

  assign wdt_intr = intr_q;
  assign cnt_val  = cnt_q;

endmodule

// File: tb/tb_wdt_rst_pulse_gen.sv
// Directed and randomized checks of wdt_rst_pulse_gen against arithmetic timing rules.
module tb_wdt_rst_pulse_gen;

  logic        pclk = 1'b0;
  logic        rst, wdt_en, rmod, restart, intr_clr;
  logic [15:0] top;
  logic [2:0]  rpl;
  logic        wdt_rst, wdt_intr;
  logic [15:0] cnt_val;
  logic        wdt_rst_hc, wdt_intr_hc;
  logic [15:0] cnt_val_hc;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 pclk = ~pclk;

  wdt_rst_pulse_gen #(.CNT_W(16), .HC_RPL(0), .DFLT_RPL(0)) dut (
    .pclk(pclk), .rst(rst), .wdt_en(wdt_en), .rmod(rmod), .restart(restart),
    .intr_clr(intr_clr), .top(top), .rpl(rpl),
    .wdt_rst(wdt_rst), .wdt_intr(wdt_intr), .cnt_val(cnt_val)
  );

  wdt_rst_pulse_gen #(.CNT_W(16), .HC_RPL(1), .DFLT_RPL(2)) dut_hc (
    .pclk(pclk), .rst(rst), .wdt_en(wdt_en), .rmod(rmod), .restart(restart),
    .intr_clr(intr_clr), .top(top), .rpl(rpl),
    .wdt_rst(wdt_rst_hc), .wdt_intr(wdt_intr_hc), .cnt_val(cnt_val_hc)
  );

  // Reference timing, counted in edges from the edge that first samples wdt_en=1.
  function automatic int exp_width(input int code);
    return 2 << code;
  endfunction
  function automatic int exp_intr_t(input int t);
    return t + 2;
  endfunction
  function automatic int exp_rise_t(input int t, input int m);
    return (m != 0) ? 2 * t + 3 : t + 2;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wdt_en = 1'b0; rmod = 1'b0; restart = 1'b0; intr_clr = 1'b0;
    top = '0; rpl = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_rise(input bit hc, input int limit, output int t);
    t = 0;
    while (!(hc ? wdt_rst_hc : wdt_rst) && t < limit) begin step(); t++; end
  endtask

  task automatic wait_intr(input int limit, output int t);
    t = 0;
    while (!wdt_intr && t < limit) begin step(); t++; end
  endtask

  // Counts consecutive high observations; leaves time just after the falling edge.
  task automatic meas_width(input bit hc, input int limit, output int w);
    w = 0;
    while ((hc ? wdt_rst_hc : wdt_rst) && w < limit) begin w++; step(); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, w, w0, k, hi, tp, cd, m;

    // Reset state
    do_reset();
    chk("reset_rst", wdt_rst, 0);
    chk("reset_intr", wdt_intr, 0);
    chk("reset_cnt", cnt_val, 0);

    // Basic reset-only timeout, then counting resumes
    top = 16'd9; rpl = 3'd3; rmod = 1'b0; wdt_en = 1'b1;
    wait_rise(0, 100, t);   chk("t1_rise", t, exp_rise_t(9, 0));
    meas_width(0, 600, w);  chk("t1_width", w, exp_width(3));
    chk("t1_cnt_after", cnt_val, 9);
    chk("t1_intr_after", wdt_intr, 0);
    wait_rise(0, 100, t);   chk("t1_rise2", t, 10);

    // Pulse width sweep
    for (int c = 0; c < 8; c++) begin
      do_reset();
      top = 16'd3; rpl = 3'(c); wdt_en = 1'b1;
      wait_rise(0, 100, t);  chk("t2_rise", t, exp_rise_t(3, 0));
      meas_width(0, 600, w); chk("t2_width", w, exp_width(c));
    end

    // Hard-coded pulse length ignores rpl
    do_reset();
    top = 16'd3; rpl = 3'd7; wdt_en = 1'b1;
    wait_rise(1, 100, t);  chk("t2_hc_rise", t, 5);
    meas_width(1, 600, w); chk("t2_hc_width", w, 8);

    // top=0 fires on the edge after enable's load
    do_reset();
    top = 16'd0; rpl = 3'd0; wdt_en = 1'b1;
    wait_rise(0, 100, t);  chk("t_top0_rise", t, exp_rise_t(0, 0));

    // Interrupt mode, no kick
    do_reset();
    top = 16'd5; rpl = 3'd1; rmod = 1'b1; wdt_en = 1'b1;
    wait_intr(100, t);     chk("t3_intr", t, exp_intr_t(5));
    wait_rise(0, 100, w);  chk("t3_rise", t + w, exp_rise_t(5, 1));
    chk("t3_intr_at_rise", wdt_intr, 1);
    meas_width(0, 600, w); chk("t3_width", w, exp_width(1));
    chk("t3_intr_after", wdt_intr, 0);

    // Interrupt cleared two cycles after it rises
    do_reset();
    top = 16'd5; rpl = 3'd1; rmod = 1'b1; wdt_en = 1'b1;
    wait_intr(100, t);     chk("t3b_intr", t, 7);
    step(); step();
    intr_clr = 1'b1; step(); intr_clr = 1'b0;
    chk("t3b_intr_clr", wdt_intr, 0);
    chk("t3b_cnt_reload", cnt_val, 5);
    hi = 0;
    for (int i = 0; i < 5; i++) begin step(); if (wdt_rst) hi++; end
    chk("t3b_no_pulse", hi, 0);

    // Restart exactly on terminal count, both modes
    for (int mm = 0; mm < 2; mm++) begin
      do_reset();
      top = 16'd4; rmod = mm[0]; wdt_en = 1'b1;
      step(); k = 0;
      while (cnt_val != 0 && k < 50) begin step(); k++; end
      restart = 1'b1; step(); restart = 1'b0;
      chk("t4_cnt", cnt_val, 4);
      chk("t4_rst", wdt_rst, 0);
      chk("t4_intr", wdt_intr, 0);
    end

    // Mid-pulse rpl change and disable are ignored
    do_reset();
    top = 16'd3; rpl = 3'd3; rmod = 1'b0; wdt_en = 1'b1;
    wait_rise(0, 100, t);  chk("t5_rise", t, 5);
    w0 = 0;
    for (int i = 0; i < 4; i++) begin if (wdt_rst) w0++; step(); end
    rpl = 3'd0; wdt_en = 1'b0; restart = 1'b1;
    meas_width(0, 600, w); chk("t5_width", w0 + w, 16);
    restart = 1'b0;
    chk("t5_idle_cnt", cnt_val, 0);
    chk("t5_idle_intr", wdt_intr, 0);
    step(); step(); step();
    chk("t5_idle_rst", wdt_rst, 0);
    chk("t5_idle_cnt2", cnt_val, 0);

    // Synchronous reset mid-pulse
    do_reset();
    top = 16'd2; rpl = 3'd2; wdt_en = 1'b1;
    wait_rise(0, 100, t);  chk("t5b_rise", t, 4);
    step(); step();
    rst = 1'b1; step();
    chk("t5b_rst", wdt_rst, 0);
    chk("t5b_intr", wdt_intr, 0);
    chk("t5b_cnt", cnt_val, 0);
    rst = 1'b0;

    // Randomized timeouts in both modes
    for (int r = 0; r < 12; r++) begin
      do_reset();
      tp = $urandom_range(0, 20); cd = $urandom_range(0, 4); m = $urandom_range(0, 1);
      top = 16'(tp); rpl = 3'(cd); rmod = m[0]; wdt_en = 1'b1;
      if (m != 0) begin
        wait_intr(200, t);    chk("rnd_intr", t, exp_intr_t(tp));
        wait_rise(0, 200, w); chk("rnd_rise_m1", t + w, exp_rise_t(tp, 1));
      end else begin
        wait_rise(0, 200, t); chk("rnd_rise_m0", t, exp_rise_t(tp, 0));
      end
      meas_width(0, 600, w);  chk("rnd_width", w, exp_width(cd));
      chk("rnd_cnt_after", cnt_val, tp);
      chk("rnd_intr_after", wdt_intr, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
